logic_pipe_unit: RTL and testbench
==================================

LOGIC_PIPE_UNIT -- requirements
Module: logic_pipe_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the transaction counter, legal range 4..32.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  the source presents a valid operation.
REQ-006 in_ready  output  1  the unit accepts an operation in this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  function select: 0 OR, 1 AND, 2 NOR, 3 NAND, 4 NOT, 5 XOR, 6 XNOR, 7 BUFFER.
REQ-010 out_valid  output  1  the result is valid.
REQ-011 out_ready  input  1  the sink accepts the result.
REQ-012 y  output  WIDTH  bitwise result.
REQ-013 zero  output  1  high when y equals all zeros.
REQ-014 parity  output  1  XOR-reduction of y.
REQ-015 clr_cnt  input  1  synchronous clear of txn_cnt.
REQ-016 txn_cnt  output  CNT_W  count of accepted input transactions.

Function
REQ-017 The unit SHALL accept an input when in_valid && in_ready are both high at a rising edge.
REQ-018 The result SHALL be bitwise per op, with NOT = ~a and BUFFER = a; operand b SHALL be ignored for ops 4 and 7.
REQ-019 The datapath SHALL be a two-stage pipeline.
 - S1 registers a, b and op.
 - S2 registers y, zero and parity computed from S1.
REQ-020 Latency SHALL be exactly 2 cycles from acceptance to out_valid when the unit is not stalled.
REQ-021 S2 SHALL load when S1 is valid and either S2 is empty or S2 is being consumed (out_valid && out_ready).
REQ-022 in_ready SHALL be combinational: high when S1 is empty or S1 is moving to S2 in this cycle.
 - Full throughput SHALL be one operation per cycle while out_ready is held high.
REQ-023 While out_valid is high and out_ready is low, y, zero and parity SHALL hold stable.
 - No accepted operation SHALL be lost or duplicated.
REQ-024 When both stages are full and out_ready is low, in_ready SHALL be low.
REQ-025 A simultaneous consume at S2, advance S1 to S2, and accept into S1 SHALL all occur in the same cycle.
REQ-026 txn_cnt SHALL increment by 1 on each accepted input and saturate at 2^CNT_W-1 (no wrap).
REQ-027 clr_cnt SHALL take priority over increment; if clr_cnt is high in an accept cycle, txn_cnt SHALL become 0.
REQ-028 The ordering of results SHALL equal the order of acceptance.

Reset
REQ-029 While rst is high, the S1 and S2 valid flags, out_valid, y, zero, parity and txn_cnt SHALL be 0 asynchronously.
 - zero SHALL read 0 in reset despite y being 0, because it is registered.
REQ-030 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; no out_valid SHALL follow for them.
REQ-032 The first acceptance SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-033 Reset with WIDTH=8 -> all outputs 0, in_ready=1, txn_cnt=0.
REQ-034 Truth-table sweep: all 8 ops, with a,b taking every pair from {0x00,0xFF,0xA5,0x5A}, out_ready=1 -> correct y two cycles later.
 - Example: op=5, a=0xA5, b=0x5A -> y=0xFF, zero=0, parity=0.
 - Example: op=1, a=0xA5, b=0x5A -> y=0x00, zero=1.
REQ-035 Back-pressure: issue 4 ops back-to-back, hold out_ready=0 for 5 cycles.
 - in_ready SHALL drop after 2 accepts and y SHALL hold.
 - On release, all 4 results SHALL emerge in order, with txn_cnt=4.
REQ-036 Saturation with CNT_W=4: 20 accepts -> txn_cnt=15; clr_cnt pulsed in an accept cycle -> txn_cnt=0.
REQ-037 Mid-stream reset: assert rst with 2 ops in flight -> out_valid=0 immediately and no stale result after release.
REQ-038 Random stimulus on in_valid and out_ready (WIDTH=13) against a reference queue model -> zero mismatches over 10000 transactions.

Source files
------------

// File: rtl/logic_pipe_unit.sv
// -----------------------------------------------------------------------------
// logic_pipe_unit
// Two-stage valid/ready pipeline that applies a bitwise logic function to two
// operands and also reports a zero flag and the parity of the result. It keeps
// a saturating count of the accepted input operations.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   source presents an operation
//   in_ready   unit accepts an operation this cycle (combinational)
//   a, b       operands (WIDTH bits)
//   op         0 OR, 1 AND, 2 NOR, 3 NAND, 4 NOT a, 5 XOR, 6 XNOR, 7 BUFFER a
//   out_valid  result valid
//   out_ready  sink accepts the result
//   y          bitwise result (WIDTH bits)
//   zero       y is all zeros
//   parity     XOR-reduction of y
//   clr_cnt    synchronous clear of txn_cnt (wins over increment)
//   txn_cnt    saturating count of accepted operations (CNT_W bits)
// -----------------------------------------------------------------------------
module logic_pipe_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] txn_cnt
);

  // Stage 1: captured operands
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [2:0]       s1_op_reg;

  // Stage 2: result and flags
  logic             s2_valid_reg;
  logic [WIDTH-1:0] y_reg;
  logic             zero_reg;
  logic             parity_reg;

  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] y_next;
  logic             s2_load;
  logic             accept;

  // S2 takes S1's result when it is empty or its current result leaves now.
  assign s2_load  = s1_valid_reg && (!s2_valid_reg || out_ready);
  // S1 can take a new operation when it is empty or draining into S2.
  assign in_ready = !s1_valid_reg || s2_load;
  assign accept   = in_valid && in_ready;

  // Per-bit function evaluation from the stage 1 registers.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        y_next[gi] = 1'b0;
        case (s1_op_reg)
          3'd0:    y_next[gi] = s1_a_reg[gi] | s1_b_reg[gi];
          3'd1:    y_next[gi] = s1_a_reg[gi] & s1_b_reg[gi];
          3'd2:    y_next[gi] = ~(s1_a_reg[gi] | s1_b_reg[gi]);
          3'd3:    y_next[gi] = ~(s1_a_reg[gi] & s1_b_reg[gi]);
          3'd4:    y_next[gi] = ~s1_a_reg[gi];
          3'd5:    y_next[gi] = s1_a_reg[gi] ^ s1_b_reg[gi];
          3'd6:    y_next[gi] = ~(s1_a_reg[gi] ^ s1_b_reg[gi]);
          default: y_next[gi] = s1_a_reg[gi];
        endcase
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= '0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_a_reg     <= a;
      s1_b_reg     <= b;
      s1_op_reg    <= op;
    end else if (s2_load) begin
      s1_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      y_reg        <= '0;
      zero_reg     <= 1'b0;
      parity_reg   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= 1'b1;
      y_reg        <= y_next;
      zero_reg     <= ~|y_next;
      parity_reg   <= ^y_next;
    end else if (out_ready) begin
      // Result consumed with nothing behind it; data registers hold.
      s2_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr_cnt) begin
      cnt_reg <= '0;
    end else if (accept && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign out_valid = s2_valid_reg;
  assign y         = y_reg;
  assign zero      = zero_reg;
  assign parity    = parity_reg;
  assign txn_cnt   = cnt_reg;

endmodule

// File: tb/tb_logic_pipe_unit.sv
module tb_logic_pipe_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, CNT_W=4 (directed tests, saturation)
  logic       in_valid8 = 1'b0, out_ready8 = 1'b0, clr8 = 1'b0;
  logic       in_ready8, out_valid8, zero8, parity8;
  logic [7:0] a8 = '0, b8 = '0, y8;
  logic [2:0] op8 = '0;
  logic [3:0] txn8;

  // Instance B: WIDTH=13, CNT_W=16 (random traffic)
  logic        in_valid13 = 1'b0, out_ready13 = 1'b0, clr13 = 1'b0;
  logic        in_ready13, out_valid13, zero13, parity13;
  logic [12:0] a13 = '0, b13 = '0, y13;
  logic [2:0]  op13 = '0;
  logic [15:0] txn13;

  logic_pipe_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .y(y8), .zero(zero8), .parity(parity8), .clr_cnt(clr8), .txn_cnt(txn8)
  );

  logic_pipe_unit #(.WIDTH(13), .CNT_W(16)) dut13 (
    .clk(clk), .rst(rst), .in_valid(in_valid13), .in_ready(in_ready13),
    .a(a13), .b(b13), .op(op13), .out_valid(out_valid13), .out_ready(out_ready13),
    .y(y13), .zero(zero13), .parity(parity13), .clr_cnt(clr13), .txn_cnt(txn13)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] q8[$];
  logic [63:0] q13[$];
  int cons8 = 0;
  int cons13 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the logic function written directly from the op table.
  function automatic logic [63:0] ref_y(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input int w);
    logic [63:0] r;
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (op)
      3'd0: r = a | b;
      3'd1: r = a & b;
      3'd2: r = ~(a | b);
      3'd3: r = ~(a & b);
      3'd4: r = ~a;
      3'd5: r = a ^ b;
      3'd6: r = ~(a ^ b);
      default: r = a;
    endcase
    return r & m;
  endfunction

  // One cycle on instance A: drive at the falling edge, then score the
  // transfers that the coming rising edge will perform.
  task automatic step8(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [2:0] iop, input logic ordy, input logic iclr,
                       output logic acc);
    logic [63:0] e;
    @(negedge clk);
    in_valid8 = iv; a8 = ia; b8 = ib; op8 = iop; out_ready8 = ordy; clr8 = iclr;
    #1;
    if (out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        check("unexpected_out8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        check("y8", {56'd0, y8}, e);
        check("flags8", {62'd0, zero8, parity8}, {62'd0, (e == 64'd0), ^e});
        cons8++;
      end
    end
    acc = iv && in_ready8;
    if (acc) q8.push_back(ref_y(iop, {56'd0, ia}, {56'd0, ib}, 8));
  endtask

  task automatic step13(input logic iv, input logic [12:0] ia, input logic [12:0] ib,
                        input logic [2:0] iop, input logic ordy, output logic acc);
    logic [63:0] e;
    @(negedge clk);
    in_valid13 = iv; a13 = ia; b13 = ib; op13 = iop; out_ready13 = ordy;
    #1;
    if (out_valid13 && out_ready13) begin
      if (q13.size() == 0) begin
        check("unexpected_out13", 64'd1, 64'd0);
      end else begin
        e = q13.pop_front();
        check("y13", {zero13, parity13, 49'd0, y13}, {(e == 64'd0), ^e, 49'd0, e[12:0]});
        cons13++;
      end
    end
    acc = iv && in_ready13;
    if (acc) q13.push_back(ref_y(iop, {51'd0, ia}, {51'd0, ib}, 13));
  endtask

  logic [7:0] vals[4];
  logic [7:0] bp_a[4];
  logic       acc;
  logic [7:0] y_hold;
  int         idx;
  int         cyc;
  int         acc13;

  initial begin
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'hA5; vals[3] = 8'h5A;
    bp_a[0] = 8'h3C; bp_a[1] = 8'hC3; bp_a[2] = 8'h0F; bp_a[3] = 8'hF0;

    // ---- Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid8}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready8}, 64'd1);
    check("rst_y", {56'd0, y8}, 64'd0);
    check("rst_zero_parity", {62'd0, zero8, parity8}, 64'd0);
    check("rst_txn", {60'd0, txn8}, 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // ---- Back-pressure: 4 ops back-to-back, sink stalled for 5 cycles
    idx = 0;
    y_hold = '0;
    for (int c = 0; c < 40 && cons8 < 4; c++) begin
      step8(idx < 4, bp_a[idx % 4], 8'h55, 3'd5, (c >= 5), 1'b0, acc);
      if (c == 2) y_hold = y8;
      if (c >= 2 && c <= 4) begin
        check("bp_in_ready_low", {63'd0, in_ready8}, 64'd0);
        check("bp_accepts", idx, 2);
        check("bp_y_hold", {56'd0, y8}, {56'd0, bp_a[0] ^ 8'h55});
        check("bp_y_stable", {56'd0, y8}, {56'd0, y_hold});
        check("bp_out_valid", {63'd0, out_valid8}, 64'd1);
      end
      if (acc) idx++;
    end
    check("bp_all_consumed", cons8, 4);
    check("bp_txn", {60'd0, txn8}, 64'd4);

    // ---- Truth-table sweep at full throughput; checks 2-cycle latency
    for (int i = 0; i <= 130; i++) begin
      if (i < 128)
        step8(1'b1, vals[(i / 4) % 4], vals[i % 4], 3'(i / 16), 1'b1, 1'b0, acc);
      else
        step8(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
      check("sweep_out_valid", {63'd0, out_valid8}, {63'd0, (i >= 2 && i < 130)});
      if (i < 128) check("sweep_in_ready", {63'd0, in_ready8}, 64'd1);
    end

    // ---- Counter saturation and clear
    check("sat_txn", {60'd0, txn8}, 64'd15);
    step8(1'b1, 8'h12, 8'h34, 3'd0, 1'b1, 1'b1, acc);
    check("clr_accepted", {63'd0, acc}, 64'd1);
    step8(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
    check("clr_txn_zero", {60'd0, txn8}, 64'd0);
    step8(1'b1, 8'h77, 8'h00, 3'd4, 1'b1, 1'b0, acc);
    step8(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
    check("txn_after_clr", {60'd0, txn8}, 64'd1);
    repeat (3) step8(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
    check("drain_empty", q8.size(), 0);

    // ---- Mid-stream reset with two operations in flight
    step8(1'b1, 8'hA5, 8'h5A, 3'd1, 1'b0, 1'b0, acc);
    step8(1'b1, 8'hA5, 8'h5A, 3'd6, 1'b0, 1'b0, acc);
    step8(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, acc);
    check("mid_full", {63'd0, out_valid8}, 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid8}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready8}, 64'd1);
    check("mid_rst_flags", {54'd0, y8, zero8, parity8}, 64'd0);
    check("mid_rst_txn", {60'd0, txn8}, 64'd0);
    q8.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    step8(1'b1, 8'hF0, 8'h0F, 3'd3, 1'b1, 1'b0, acc);
    check("first_accept", {63'd0, acc}, 64'd1);
    step8(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
    check("no_stale", {63'd0, out_valid8}, 64'd0);
    step8(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
    check("post_rst_result", {63'd0, out_valid8}, 64'd1);
    step8(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, acc);
    check("post_rst_idle", {63'd0, out_valid8}, 64'd0);

    // ---- Random traffic on the 13-bit instance
    acc13 = 0;
    cyc = 0;
    while (cons13 < 10000 && cyc < 40000) begin
      step13(($urandom_range(0, 3) != 0), 13'($urandom), 13'($urandom),
             3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), acc);
      if (acc) acc13++;
      cyc++;
    end
    check("rand_consumed", cons13, 10000);
    step13(1'b0, 13'd0, 13'd0, 3'd0, 1'b0, acc);
    check("rand_txn", {48'd0, txn13}, acc13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
